// File: rtl/cmd_arb_pkg.sv
// cmd_arb_pkg: FSM state encoding, default timing/data constants and requester IDs
// shared by the command-port arbiter and its picker.
package cmd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam int          TIMEOUT_CYC_DEF = 16;
    localparam logic [31:0] TMO_DAT_DEF     = 32'hDEAD_0BAD;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/cmd_arb_pick.sv
// cmd_arb_pick: combinational two-way picker; on a tie the favoured requester (rr_i) wins
// unless FIXED_PRIO forces M0.
module cmd_arb_pick
    import cmd_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic val0_i,
    input  logic val1_i,
    input  logic rr_i,
    output logic gnt_id_o,
    output logic gnt_any_o
);

    assign gnt_any_o = val0_i | val1_i;
    assign gnt_id_o  = (val0_i && val1_i) ? (FIXED_PRIO ? M0 : rr_i) : (val1_i ? M1 : M0);

endmodule

// File: rtl/cmd_arb.sv
// cmd_arb: two-requester arbiter/sequencer in front of the config macro command port.
// Define CMD_ARB_STAT_EN to enable the saturating timeout counter on tmo_cnt.
module cmd_arb
    import cmd_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [31:0] TMO_DAT     = TMO_DAT_DEF,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_val,
    input  logic [31:0] m0_adr,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_dat,
    output logic        m0_ack,
    output logic [31:0] m0_rd_dat,
    input  logic        m1_val,
    input  logic [31:0] m1_adr,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_dat,
    output logic        m1_ack,
    output logic [31:0] m1_rd_dat,
    output logic        cmd_val,
    output logic [31:0] cmd_adr,
    output logic        cmd_we,
    output logic [3:0]  cmd_sel,
    output logic [31:0] cmd_dat,
    input  logic        rd_ack,
    input  logic [31:0] rd_dat,
    output logic        tmo_err,
    output logic [7:0]  tmo_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 2);

    state_e      state_q, state_d;
    logic        own_q, own_d;
    logic [31:0] adr_q, adr_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        rr_q, rr_d;
    logic        tmo_err_q, tmo_err_d;
    logic [31:0] rd0_q, rd0_d;
    logic [31:0] rd1_q, rd1_d;
    logic        gnt_id, gnt_any, tmo_hit, load;
    logic [31:0] load_dat;

    cmd_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .val0_i   (m0_val),
        .val1_i   (m1_val),
        .rr_i     (rr_q),
        .gnt_id_o (gnt_id),
        .gnt_any_o(gnt_any)
    );

    // a real rd_ack in the last wait cycle beats the timeout
    assign tmo_hit = (state_q == WAIT_RD) && !rd_ack && (wcnt_q == WAIT_LAST);

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        adr_d     = adr_q;
        we_d      = we_q;
        sel_d     = sel_q;
        dat_d     = dat_q;
        wcnt_d    = wcnt_q;
        rr_d      = rr_q;
        tmo_err_d = tmo_err_q | tmo_hit;
        load      = 1'b0;
        load_dat  = rd_dat;
        case (state_q)
            IDLE: if (gnt_any) begin
                own_d   = gnt_id;
                adr_d   = gnt_id ? m1_adr : m0_adr;
                we_d    = gnt_id ? m1_we  : m0_we;
                sel_d   = gnt_id ? m1_sel : m0_sel;
                dat_d   = gnt_id ? m1_dat : m0_dat;
                state_d = ISSUE;
            end
            ISSUE: if (we_q || rd_ack) begin
                load     = 1'b1;
                load_dat = we_q ? 32'h0 : rd_dat;
                state_d  = RESP;
            end else begin
                wcnt_d  = 8'd0;
                state_d = WAIT_RD;
            end
            WAIT_RD: if (rd_ack || tmo_hit) begin
                load     = 1'b1;
                load_dat = rd_ack ? rd_dat : TMO_DAT;
                state_d  = RESP;
            end else begin
                wcnt_d = wcnt_q + 8'd1;
            end
            RESP: begin
                rr_d    = ~own_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rd0_d = (load && own_q == M0) ? load_dat : rd0_q;
        rd1_d = (load && own_q == M1) ? load_dat : rd1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            own_q     <= M0;
            adr_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            dat_q     <= '0;
            wcnt_q    <= '0;
            rr_q      <= M0;
            tmo_err_q <= 1'b0;
            rd0_q     <= '0;
            rd1_q     <= '0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            adr_q     <= adr_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
            wcnt_q    <= wcnt_d;
            rr_q      <= rr_d;
            tmo_err_q <= tmo_err_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
        end
    end

    assign cmd_val   = (state_q == ISSUE);
    assign cmd_adr   = adr_q;
    assign cmd_we    = we_q;
    assign cmd_sel   = sel_q;
    assign cmd_dat   = dat_q;
    assign m0_ack    = (state_q == RESP) && (own_q == M0);
    assign m1_ack    = (state_q == RESP) && (own_q == M1);
    assign m0_rd_dat = rd0_q;
    assign m1_rd_dat = rd1_q;
    assign tmo_err   = tmo_err_q;

`ifdef CMD_ARB_STAT_EN
    logic [7:0] tmo_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_cnt_q <= '0;
        else if (tmo_hit && tmo_cnt_q != 8'hFF) tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end

    assign tmo_cnt = tmo_cnt_q;
`else
    assign tmo_cnt = '0;
`endif

endmodule

// File: tb/tb_cmd_arb.sv
// tb_cmd_arb: directed and randomized checks of cmd_arb against a transaction-level model.
module tb_cmd_arb;

    localparam int          T   = 16;
    localparam logic [31:0] TMO = 32'hDEAD_0BAD;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_val, m0_we, m1_val, m1_we, rd_ack;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, rd_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m1_ack, cmd_val, cmd_we, tmo_err;
    logic [31:0] m0_rd_dat, m1_rd_dat, cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic [7:0]  tmo_cnt;
    logic        f_m0_val, f_m1_val, f_m0_ack, f_m1_ack, f_cmd_val, f_cmd_we, f_tmo_err;
    logic [31:0] f_m0_rd_dat, f_m1_rd_dat, f_cmd_adr, f_cmd_dat;
    logic [3:0]  f_cmd_sel;
    logic [7:0]  f_tmo_cnt;

    int checks = 0;
    int errors = 0;

    // transaction-level model
    bit          pref;
    bit          tmo_m;
    int          tcnt_m;
    logic [31:0] last_rd [2];

    // results of the most recent drive_txn
    bit          seen, p1, sa, own, both;
    int          wc, lat;
    logic [31:0] ca, cd;
    logic        cw;
    logic [3:0]  cs;

    always #5 clk = ~clk;

    cmd_arb #(.TIMEOUT_CYC(T), .TMO_DAT(TMO), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_val(m0_val), .m0_adr(m0_adr), .m0_we(m0_we), .m0_sel(m0_sel), .m0_dat(m0_dat),
        .m0_ack(m0_ack), .m0_rd_dat(m0_rd_dat),
        .m1_val(m1_val), .m1_adr(m1_adr), .m1_we(m1_we), .m1_sel(m1_sel), .m1_dat(m1_dat),
        .m1_ack(m1_ack), .m1_rd_dat(m1_rd_dat),
        .cmd_val(cmd_val), .cmd_adr(cmd_adr), .cmd_we(cmd_we), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
        .rd_ack(rd_ack), .rd_dat(rd_dat), .tmo_err(tmo_err), .tmo_cnt(tmo_cnt)
    );

    cmd_arb #(.TIMEOUT_CYC(T), .TMO_DAT(TMO), .FIXED_PRIO(1'b1)) dut_fixed (
        .clk(clk), .rst(rst),
        .m0_val(f_m0_val), .m0_adr(m0_adr), .m0_we(m0_we), .m0_sel(m0_sel), .m0_dat(m0_dat),
        .m0_ack(f_m0_ack), .m0_rd_dat(f_m0_rd_dat),
        .m1_val(f_m1_val), .m1_adr(m1_adr), .m1_we(m1_we), .m1_sel(m1_sel), .m1_dat(m1_dat),
        .m1_ack(f_m1_ack), .m1_rd_dat(f_m1_rd_dat),
        .cmd_val(f_cmd_val), .cmd_adr(f_cmd_adr), .cmd_we(f_cmd_we), .cmd_sel(f_cmd_sel),
        .cmd_dat(f_cmd_dat), .rd_ack(rd_ack), .rd_dat(rd_dat), .tmo_err(f_tmo_err),
        .tmo_cnt(f_tmo_cnt)
    );

    function automatic bit win(bit v0, bit v1);
        return (v0 && v1) ? pref : v1;
    endfunction

    function automatic int exp_lat(bit we, int d);
        return we ? 1 : (d <= T - 1 ? d + 1 : T);
    endfunction

    function automatic logic [31:0] exp_dat(bit we, int d, logic [31:0] rdv);
        return we ? 32'h0 : (d <= T - 1 ? rdv : TMO);
    endfunction

    function automatic logic [7:0] exp_tcnt();
`ifdef CMD_ARB_STAT_EN
        return 8'(tcnt_m);
`else
        return 8'h0;
`endif
    endfunction

    task automatic commit(bit o, bit we, int d, logic [31:0] rdv);
        pref = ~o;
        last_rd[o] = exp_dat(we, d, rdv);
        if (!we && d > T - 1) begin
            tmo_m = 1'b1;
            if (tcnt_m < 255) tcnt_m++;
        end
    endtask

    task automatic model_reset();
        pref = 1'b0;
        tmo_m = 1'b0;
        tcnt_m = 0;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    // Raise the requested vals, pulse rd_ack d cycles after cmd_val (255 = never), and record what the DUT did.
    task automatic drive_txn(bit v0, bit v1, int d, logic [31:0] rdv);
        m0_val = v0;
        m1_val = v1;
        rd_dat = rdv;
        seen = 0; p1 = 0; sa = 0; own = 0; both = 0; wc = 0; lat = 0;
        ca = '0; cw = 1'b0; cs = '0; cd = '0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            if (cmd_val === 1'b1) begin
                seen = 1; wc = i;
                ca = cmd_adr; cw = cmd_we; cs = cmd_sel; cd = cmd_dat;
            end
        end
        if (seen) begin
            for (int c = 0; c <= 40 && !sa; c++) begin
                rd_ack = (c == d);
                @(negedge clk);
                if (c == 0) p1 = (cmd_val === 1'b0);
                if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
                    sa = 1; lat = c + 1; own = m1_ack; both = m0_ack & m1_ack;
                end
            end
        end
        rd_ack = 1'b0;
        m0_val = 1'b0;
        m1_val = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_val, m0_ack, m1_ack, tmo_err, cmd_we} !== 5'b0)
            begin errors++; $display("FAIL reset_ctl: got %b exp 00000", {cmd_val, m0_ack, m1_ack, tmo_err, cmd_we}); end
        checks++;
        if ({cmd_adr, cmd_dat, cmd_sel, m0_rd_dat, m1_rd_dat, tmo_cnt} !== '0)
            begin errors++; $display("FAIL reset_data: adr %h dat %h sel %h rd0 %h rd1 %h cnt %h exp all 0", cmd_adr, cmd_dat, cmd_sel, m0_rd_dat, m1_rd_dat, tmo_cnt); end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_b2b_rr();
        int n = 0;
        bit e;
        m0_we = 1'b1; m1_we = 1'b1;
        m0_val = 1'b1; m1_val = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
                e = win(1'b1, 1'b1);
                checks++;
                if (m1_ack !== e || m0_ack === m1_ack)
                    begin errors++; $display("FAIL rr_order[%0d]: got m0_ack=%b m1_ack=%b exp owner M%0d", n, m0_ack, m1_ack, e); end
                commit(e, 1'b1, 0, 32'h0);
                n++;
            end
        end
        m0_val = 1'b0; m1_val = 1'b0;
        checks++;
        if (n != 4) begin errors++; $display("FAIL rr_count: got %0d acks exp 4", n); end
        @(negedge clk);
    endtask

    task automatic test_fixed_prio();
        int n = 0;
        m0_we = 1'b1; m1_we = 1'b1;
        f_m0_val = 1'b1; f_m1_val = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (f_m0_ack === 1'b1 || f_m1_ack === 1'b1) begin
                checks++;
                if (f_m0_ack !== 1'b1 || f_m1_ack !== 1'b0)
                    begin errors++; $display("FAIL fixed_order[%0d]: got m0_ack=%b m1_ack=%b exp M0", n, f_m0_ack, f_m1_ack); end
                n++;
            end
        end
        f_m0_val = 1'b0; f_m1_val = 1'b0;
        checks++;
        if (n != 4) begin errors++; $display("FAIL fixed_count: got %0d acks exp 4", n); end
        @(negedge clk);
    endtask

    task automatic test_write();
        m0_adr = 32'h0; m0_dat = 32'h1234_5678; m0_we = 1'b1; m0_sel = 4'hF;
        m1_adr = $urandom; m1_dat = $urandom; m1_we = 1'b0; m1_sel = 4'h3;
        drive_txn(1'b1, 1'b0, 255, 32'h0);
        commit(1'b0, 1'b1, 0, 32'h0);
        checks++;
        if (!seen || wc != 1) begin errors++; $display("FAIL wr_cmd_start: seen=%0d at %0d exp cycle 1", seen, wc); end
        checks++;
        if ({ca, cw, cs, cd} !== {32'h0, 1'b1, 4'hF, 32'h1234_5678})
            begin errors++; $display("FAIL wr_fields: got adr %h we %b sel %h dat %h", ca, cw, cs, cd); end
        checks++;
        if (!p1) begin errors++; $display("FAIL wr_pulse: cmd_val not a single cycle"); end
        checks++;
        if (!sa || own !== 1'b0 || both || lat != 1)
            begin errors++; $display("FAIL wr_ack: seen=%0d owner=%0d both=%0d lat=%0d exp M0 lat 1", sa, own, both, lat); end
        checks++;
        if (m0_rd_dat !== 32'h0) begin errors++; $display("FAIL wr_rd_dat: got %h exp 0", m0_rd_dat); end
    endtask

    task automatic test_read_delay();
        m1_adr = 32'h0000_0040; m1_we = 1'b0; m1_sel = 4'hF; m1_dat = $urandom;
        drive_txn(1'b0, 1'b1, 3, 32'hCAFE_F00D);
        commit(1'b1, 1'b0, 3, 32'hCAFE_F00D);
        checks++;
        if (!sa || own !== 1'b1 || both || lat != 4)
            begin errors++; $display("FAIL rd_ack: seen=%0d owner=%0d lat=%0d exp M1 lat 4", sa, own, lat); end
        checks++;
        if (m1_rd_dat !== 32'hCAFE_F00D || tmo_err !== 1'b0)
            begin errors++; $display("FAIL rd_data: got %h tmo_err %b exp cafef00d 0", m1_rd_dat, tmo_err); end
        checks++;
        if (m0_rd_dat !== last_rd[0]) begin errors++; $display("FAIL rd_other: got %h exp %h", m0_rd_dat, last_rd[0]); end
    endtask

    task automatic test_coincident();
        logic [31:0] v = $urandom;
        m1_we = 1'b0;
        drive_txn(1'b0, 1'b1, T - 1, v);
        commit(1'b1, 1'b0, T - 1, v);
        checks++;
        if (!sa || own !== 1'b1 || lat != T)
            begin errors++; $display("FAIL coin_ack: seen=%0d owner=%0d lat=%0d exp M1 lat %0d", sa, own, lat, T); end
        checks++;
        if (m1_rd_dat !== v || tmo_err !== 1'b0 || tmo_cnt !== 8'h0)
            begin errors++; $display("FAIL coin_data: got %h err %b cnt %0d exp %h 0 0", m1_rd_dat, tmo_err, tmo_cnt, v); end
    endtask

    task automatic test_timeout();
        m0_we = 1'b0;
        drive_txn(1'b1, 1'b0, 255, 32'h5555_AAAA);
        commit(1'b0, 1'b0, 255, 32'h0);
        checks++;
        if (!sa || own !== 1'b0 || lat != T)
            begin errors++; $display("FAIL tmo_ack: seen=%0d owner=%0d lat=%0d exp M0 lat %0d", sa, own, lat, T); end
        checks++;
        if (m0_rd_dat !== TMO || tmo_err !== 1'b1)
            begin errors++; $display("FAIL tmo_data: got %h err %b exp %h 1", m0_rd_dat, tmo_err, TMO); end
        checks++;
        if (tmo_cnt !== exp_tcnt()) begin errors++; $display("FAIL tmo_cnt: got %0d exp %0d", tmo_cnt, exp_tcnt()); end
    endtask

    task automatic test_reset_mid();
        bit any_ack = 0;
        logic [31:0] v = $urandom;
        m0_we = 1'b1;
        drive_txn(1'b1, 1'b0, 255, 32'h0);
        commit(1'b0, 1'b1, 0, 32'h0);
        m1_adr = 32'hA5A5_0000; m1_we = 1'b0; m1_sel = 4'h9; m1_dat = 32'h1;
        m1_val = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({cmd_val, m0_ack, m1_ack, tmo_err, cmd_we} !== 5'b0 || {cmd_adr, cmd_dat, cmd_sel} !== '0)
            begin errors++; $display("FAIL midrst_cmd: val %b acks %b%b err %b adr %h exp all 0", cmd_val, m0_ack, m1_ack, tmo_err, cmd_adr); end
        checks++;
        if ({m0_rd_dat, m1_rd_dat, tmo_cnt} !== '0)
            begin errors++; $display("FAIL midrst_data: rd0 %h rd1 %h cnt %0d exp 0", m0_rd_dat, m1_rd_dat, tmo_cnt); end
        m1_val = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m0_ack === 1'b1 || m1_ack === 1'b1) any_ack = 1;
        end
        checks++;
        if (any_ack) begin errors++; $display("FAIL midrst_noack: got ack during reset exp none"); end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        m0_we = 1'b1; m1_we = 1'b1;
        drive_txn(1'b1, 1'b1, 255, 32'h0);
        checks++;
        if (!sa || own !== 1'b0) begin errors++; $display("FAIL midrst_tie: owner=%0d seen=%0d exp M0", own, sa); end
        commit(1'b0, 1'b1, 0, 32'h0);
        m1_we = 1'b0;
        drive_txn(1'b0, 1'b1, 2, v);
        commit(1'b1, 1'b0, 2, v);
        checks++;
        if (!sa || own !== 1'b1 || lat != 3 || m1_rd_dat !== v || tmo_err !== 1'b0)
            begin errors++; $display("FAIL midrst_read: owner=%0d lat=%0d data %h err %b exp M1 3 %h 0", own, lat, m1_rd_dat, tmo_err, v); end
    endtask

    task automatic test_stray();
        bit bad = 0;
        rd_dat = $urandom;
        rd_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (cmd_val !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0 ||
                m0_rd_dat !== last_rd[0] || m1_rd_dat !== last_rd[1]) bad = 1;
        end
        rd_ack = 1'b0;
        checks++;
        if (bad) begin errors++; $display("FAIL stray_idle: activity on stray rd_ack, rd0 %h rd1 %h", m0_rd_dat, m1_rd_dat); end
        m1_we = 1'b1;
        drive_txn(1'b0, 1'b1, 0, 32'hFFFF_FFFF);
        commit(1'b1, 1'b1, 0, 32'h0);
        checks++;
        if (!sa || own !== 1'b1 || lat != 1 || m1_rd_dat !== 32'h0)
            begin errors++; $display("FAIL stray_write: owner=%0d lat=%0d data %h exp M1 1 0", own, lat, m1_rd_dat); end
    endtask

    task automatic test_random(int n);
        for (int k = 0; k < n; k++) begin
            int p, d;
            bit v0, v1, eo, ew;
            logic [31:0] rdv;
            p = $urandom_range(1, 3);
            v0 = p[0]; v1 = p[1];
            m0_adr = $urandom; m0_dat = $urandom; m0_sel = 4'($urandom); m0_we = 1'($urandom);
            m1_adr = $urandom; m1_dat = $urandom; m1_sel = 4'($urandom); m1_we = 1'($urandom);
            d = ($urandom_range(0, 5) == 0) ? 255 : $urandom_range(0, T + 2);
            rdv = $urandom;
            eo = win(v0, v1);
            ew = eo ? m1_we : m0_we;
            checks++;
            drive_txn(v0, v1, d, rdv);
            if (!seen || wc != 1) begin errors++; $display("FAIL rand_cmd[%0d]: seen=%0d at %0d exp cycle 1", k, seen, wc); end
            checks++;
            if ({ca, cw, cs, cd} !== (eo ? {m1_adr, m1_we, m1_sel, m1_dat} : {m0_adr, m0_we, m0_sel, m0_dat}))
                begin errors++; $display("FAIL rand_fields[%0d]: got adr %h we %b sel %h dat %h exp M%0d fields", k, ca, cw, cs, cd, eo); end
            checks++;
            if (!p1) begin errors++; $display("FAIL rand_pulse[%0d]: cmd_val not a single cycle", k); end
            checks++;
            if (!sa || own !== eo || both) begin errors++; $display("FAIL rand_owner[%0d]: seen=%0d got M%0d both=%0d exp M%0d", k, sa, own, both, eo); end
            checks++;
            if (lat != exp_lat(ew, d)) begin errors++; $display("FAIL rand_lat[%0d]: got %0d exp %0d", k, lat, exp_lat(ew, d)); end
            commit(eo, ew, d, rdv);
            checks++;
            if (m0_rd_dat !== last_rd[0] || m1_rd_dat !== last_rd[1])
                begin errors++; $display("FAIL rand_rdat[%0d]: got %h %h exp %h %h", k, m0_rd_dat, m1_rd_dat, last_rd[0], last_rd[1]); end
            checks++;
            if (tmo_err !== tmo_m || tmo_cnt !== exp_tcnt())
                begin errors++; $display("FAIL rand_tmo[%0d]: got err %b cnt %0d exp %b %0d", k, tmo_err, tmo_cnt, tmo_m, exp_tcnt()); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        m0_val = 1'b0; m1_val = 1'b0; f_m0_val = 1'b0; f_m1_val = 1'b0;
        m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0;
        m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0;
        rd_ack = 1'b0; rd_dat = '0;
        model_reset();
        test_reset();
        test_b2b_rr();
        test_fixed_prio();
        test_write();
        test_read_delay();
        test_coincident();
        test_timeout();
        test_reset_mid();
        test_stray();
        test_random(40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
